bin2seg_enc: RTL
================

// Module: bin2seg_enc
// PURPOSE
//   Converts an unsigned binary RPM value into four 7-segment digit patterns plus
//   decimal-point enables for the downstream 4-digit display multiplexer.
//   Sequential double-dabble conversion (one shift per clk), then a registered
//   digit-to-segment encode. Sits between the RPM measurement counter and the
//   segment mux.
//   Outputs are active-high (1 = segment lit); the mux inverts them.
// PARAMETERS
//   VAL_W     16     width of binary input value (4..16)
//   MAX_VAL   9999   largest displayable value; any input above it shows "----"
// PORTS
//   clk        in   1      system clock, 50 MHz
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      value/dp_pos present; accepted when in_valid & in_ready at posedge
//   in_ready   out  1      high only in IDLE
//   value      in   VAL_W  unsigned binary value
//   dp_pos     in   4      decimal-point enables, bit0 = ones digit
//   seg_a      out  8      ones digit pattern {1'b0,g,f,e,d,c,b,a}
//   seg_b      out  8      tens digit pattern
//   seg_c      out  8      hundreds digit pattern
//   seg_d      out  8      thousands digit pattern
//   dp_k       out  4      registered copy of dp_pos, updated with segments
//   ovf        out  1      high while displayed value is the overflow pattern
//   upd        out  1      one-cycle pulse: new outputs valid this cycle
// BEHAVIOUR
//   - Clock/reset: single clock clk; rst_n asynchronous, active low.
//   - Reset values: seg_a..seg_d = 8'h00 (blank), dp_k = 0, ovf = 0, upd = 0,
//     FSM = IDLE, so in_ready = 1.
//   - FSM states: IDLE -> CONV -> OUT -> IDLE.
//   - IDLE, edge N, accept:
//       - capture value into shift reg; clear 16-bit BCD reg; cnt = 0;
//       - latch dp_pos; ovf_n = (value > MAX_VAL); go to CONV.
//   - CONV, one iteration per clk:
//       - add 3 to every BCD nibble >= 5;
//       - shift {bcd,shreg} left by 1;
//       - after VAL_W iterations (edges N+1..N+VAL_W) go to OUT.
//   - OUT, edge N+VAL_W+1:
//       - register encoded seg_a..seg_d, dp_k and ovf;
//       - upd = 1 for exactly the following cycle; go to IDLE.
//       - New request may be accepted at that same next edge.
//   - Latency: accept edge to new outputs = VAL_W+1 clk (17 at default).
//   - Accept interval: VAL_W+2 clk.
//   - in_valid while in_ready = 0 is ignored, not queued. The producer holds or re-sends.
//   - Outputs hold their last value between updates; the mux may sample them at any time.
//   - Encoding (gfedcba):
//       - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F;
//       - BCD nibble > 9 is impossible; if it occurs, encode as 8'h00.
//   - Overflow (value > MAX_VAL):
//       - all four digits = 8'h40 ("-"), ovf = 1, dp_k = 0;
//       - BCD result is discarded.
//       - With default parameters, values 10000..65535 overflow.
//   - Wrap/clamp: no wrap-around; display never shows value mod 10000.
//   - Reset asserted mid-CONV/OUT: conversion aborted, outputs go to reset values
//     immediately; no upd pulse.
// CONFIGURATION
//   SEG_LZB_EN defined (leading-zero blanking):
//     - leading zero digits (thousands, then hundreds, then tens) are output as 8'h00;
//     - the ones digit is always shown, so value 0 displays "   0";
//     - a digit whose dp_pos bit is set is never blanked, nor are digits to its right;
//     - overflow pattern unaffected.
//   SEG_LZB_EN undefined: all four digits always shown, e.g. 42 -> "0042".
// TESTING
//   - Reset: rst_n=0 mid-conversion -> seg_*=00, dp_k=0, ovf=0, upd=0, in_ready=1
//     asynchronously.
//   - value=1234, dp_pos=0 -> 17 clk after accept:
//       - seg_d=06, seg_c=5B, seg_b=4F, seg_a=66; upd pulses once; ovf=0.
//   - value=42:
//       - no LZB: seg_d=3F, seg_c=3F, seg_b=66, seg_a=5B;
//       - SEG_LZB_EN: seg_d=00, seg_c=00, seg_b=66, seg_a=5B.
//   - value=0, dp_pos=4'b0100, SEG_LZB_EN -> seg_d=00, seg_c=3F, seg_b=3F, seg_a=3F,
//     dp_k=0100.
//   - value=10000, then 65535 -> all seg_*=40, ovf=1, dp_k=0.
//     Next value=9999 -> all seg_*=6F, ovf=0.
//   - Busy drop:
//       - second in_valid (value=5555) asserted 3 clk after accepting 1111 is ignored;
//       - outputs show 1111;
//       - holding in_valid until in_ready=1 then shows 5555.

Source files
------------

// File: rtl/bin2seg_enc.sv
// Binary-to-7-segment encoder: sequential double-dabble to 4 BCD digits, then registered encode.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module bin2seg_enc #(
    parameter int VAL_W   = 16,
    parameter int MAX_VAL = 9999
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VAL_W-1:0] value,
    input  logic [3:0]       dp_pos,
    output logic [7:0]       seg_a,
    output logic [7:0]       seg_b,
    output logic [7:0]       seg_c,
    output logic [7:0]       seg_d,
    output logic [3:0]       dp_k,
    output logic             ovf,
    output logic             upd
);

    typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, OUT = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [VAL_W-1:0] shreg_q, shreg_d;
    logic [15:0]      bcd_q, bcd_d, bcd_adj;
    logic [4:0]       cnt_q, cnt_d;
    logic [3:0]       dp_lat_q, dp_lat_d;
    logic             ovf_n_q, ovf_n_d;
    logic [3:0][7:0]  digs_q, digs_d, enc;
    logic [3:0]       dp_k_q, dp_k_d;
    logic             ovf_q, ovf_d;
    logic             upd_q, upd_d;
    logic [3:0]       blank;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'h3F;
            4'd1:    seg7 = 8'h06;
            4'd2:    seg7 = 8'h5B;
            4'd3:    seg7 = 8'h4F;
            4'd4:    seg7 = 8'h66;
            4'd5:    seg7 = 8'h6D;
            4'd6:    seg7 = 8'h7D;
            4'd7:    seg7 = 8'h07;
            4'd8:    seg7 = 8'h7F;
            4'd9:    seg7 = 8'h6F;
            default: seg7 = 8'h00;
        endcase
    endfunction

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // A dp-marked digit stops the blanking chain for itself and everything to its right.
    always_comb begin
        blank = '0;
`ifdef SEG_LZB_EN
        blank[3] = (bcd_q[15:12] == 4'd0) && !dp_lat_q[3];
        blank[2] = blank[3] && (bcd_q[11:8] == 4'd0) && !dp_lat_q[2];
        blank[1] = blank[2] && (bcd_q[7:4] == 4'd0) && !dp_lat_q[1];
`endif
        for (int i = 0; i < 4; i++)
            enc[i] = blank[i] ? 8'h00 : seg7(bcd_q[4*i +: 4]);
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        dp_lat_d = dp_lat_q;
        ovf_n_d  = ovf_n_q;
        digs_d   = digs_q;
        dp_k_d   = dp_k_q;
        ovf_d    = ovf_q;
        upd_d    = 1'b0;
        case (state_q)
            IDLE: if (in_valid) begin
                shreg_d  = value;
                bcd_d    = '0;
                cnt_d    = '0;
                dp_lat_d = dp_pos;
                ovf_n_d  = 32'(value) > 32'(MAX_VAL);
                state_d  = CONV;
            end
            CONV: begin
                {bcd_d, shreg_d} = {bcd_adj, shreg_q} << 1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(VAL_W - 1))
                    state_d = OUT;
            end
            OUT: begin
                if (ovf_n_q) begin
                    digs_d = {4{8'h40}};
                    dp_k_d = 4'd0;
                    ovf_d  = 1'b1;
                end else begin
                    digs_d = enc;
                    dp_k_d = dp_lat_q;
                    ovf_d  = 1'b0;
                end
                upd_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            dp_lat_q <= '0;
            ovf_n_q  <= 1'b0;
            digs_q   <= '0;
            dp_k_q   <= '0;
            ovf_q    <= 1'b0;
            upd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            dp_lat_q <= dp_lat_d;
            ovf_n_q  <= ovf_n_d;
            digs_q   <= digs_d;
            dp_k_q   <= dp_k_d;
            ovf_q    <= ovf_d;
            upd_q    <= upd_d;
        end
    end

    assign in_ready = (state_q == IDLE);
    assign seg_a    = digs_q[0];
    assign seg_b    = digs_q[1];
    assign seg_c    = digs_q[2];
    assign seg_d    = digs_q[3];
    assign dp_k     = dp_k_q;
    assign ovf      = ovf_q;
    assign upd      = upd_q;

endmodule
